// File: rtl/arbiter_pkg.sv
// Shared definitions for the crossbar round-robin arbiters.
// rr_next is the generic search reused by other arbiters, which pass their own port count.
package arbiter_pkg;

    localparam int unsigned ARB_DEFAULT_WIDTH = 3;
    localparam int unsigned ARB_MAX_WIDTH     = 32;
    localparam int unsigned ARB_IDX_W         = 5;

    localparam logic [ARB_MAX_WIDTH-1:0] ARB_ONE = 32'd1;

    typedef struct packed {
        logic                     valid;
        logic [ARB_IDX_W-1:0]     idx;
        logic [ARB_MAX_WIDTH-1:0] onehot;
    } rr_result_t;

    // Search req from last+1 upward, wrapping modulo width; width must be 2..ARB_MAX_WIDTH.
    function automatic rr_result_t rr_next(
        input logic [ARB_MAX_WIDTH-1:0] req,
        input logic [ARB_IDX_W-1:0]     last,
        input logic [ARB_IDX_W:0]       width
    );
        rr_result_t           res;
        logic [ARB_IDX_W:0]   off_w;
        logic [ARB_IDX_W:0]   cand;
        res = '0;
        // Walk the offsets from far to near so the nearest hit is the one that sticks.
        for (int off = ARB_MAX_WIDTH; off >= 1; off--) begin
            off_w = (ARB_IDX_W+1)'(off);
            cand  = {1'b0, last} + off_w;
            if (cand >= width) begin
                cand = cand - width;
            end else begin
                cand = cand;
            end
            if ((off_w <= width) && req[cand[ARB_IDX_W-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = cand[ARB_IDX_W-1:0];
            end else begin
                res = res;
            end
        end
        if (res.valid) begin
            res.onehot = ARB_ONE << res.idx;
        end else begin
            res.onehot = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin selector: rotate the requests so last+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the winning offset back.
module rr_pick
    import arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = ARB_DEFAULT_WIDTH,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] grant
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W:0]   WIDTH_W  = (IDX_W+1)'(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] start_s;
    logic [WIDTH-1:0] rot_s;
    logic [IDX_W-1:0] off_s;
    logic [IDX_W:0]   sum_s;

    // Rotate so the search start lands on bit 0; the doubled vector supplies the wrap.
    always_comb begin
        if (last >= LAST_IDX) begin
            start_s = '0;
        end else begin
            start_s = last + IDX_W'(1'b1);
        end
        rot_s = WIDTH'({req, req} >> start_s);
    end

    // Lowest set bit of the rotated vector is the winner's distance from the start.
    always_comb begin
        off_s = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = IDX_W'(i);
            end else begin
                off_s = off_s;
            end
        end
    end

    // Map the offset back to an absolute port index and build the one-hot grant.
    always_comb begin
        valid = |rot_s;
        sum_s = {1'b0, start_s} + {1'b0, off_s};
        if (sum_s >= WIDTH_W) begin
            sum_s = sum_s - WIDTH_W;
        end else begin
            sum_s = sum_s;
        end
        idx = sum_s[IDX_W-1:0];
        if (valid) begin
            grant = ONE << idx;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/arbiter.sv
// Round-robin, packet-locking arbiter for one crossbar output port.
// A winner keeps the grant while its request stays high; the grant is registered.
module arbiter
    import arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = ARB_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] request_i,
    output logic [WIDTH-1:0] grant_o
);

    localparam int unsigned      IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [WIDTH-1:0] grant_r;
    logic [IDX_W-1:0] last_r;
    logic [WIDTH-1:0] grant_next_s;
    logic [IDX_W-1:0] last_next_s;
    logic             hold_s;
    logic             pick_valid_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic [WIDTH-1:0] pick_grant_s;

    rr_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (request_i),
        .last  (last_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s),
        .grant (pick_grant_s)
    );

    // Hold while the current holder still requests, otherwise take the round-robin pick.
    always_comb begin
        grant_next_s = grant_r;
        last_next_s  = last_r;
        hold_s       = |(grant_r & request_i);
        if (hold_s) begin
            grant_next_s = grant_r;
            last_next_s  = last_r;
        end else if (pick_valid_s) begin
            grant_next_s = pick_grant_s;
            last_next_s  = pick_idx_s;
        end else begin
            // Nobody requesting: drop the grant but keep the pointer for fairness.
            grant_next_s = '0;
            last_next_s  = last_r;
        end
    end

    // Grant and pointer registers; reset leaves index 0 with top priority.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            grant_r <= '0;
            last_r  <= LAST_IDX;
        end else begin
            grant_r <= grant_next_s;
            last_r  <= last_next_s;
        end
    end

    assign grant_o = grant_r;

endmodule

// File: tb/tb_arbiter.sv
// Self-checking bench for arbiter (WIDTH=3): a behavioural reference checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_arbiter;

    localparam int W = 3;

    logic         clk_i;
    logic         rstn_i;
    logic [W-1:0] request_i;
    logic [W-1:0] grant_o;

    int errors = 0;
    int checks = 0;

    int           m_grant = -1;
    int           m_last  = W - 1;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_prev_req = '0;

    arbiter #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .request_i (request_i),
        .grant_o   (grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int rr_search(input logic [W-1:0] req, input int last);
        for (int k = 1; k <= W; k++) begin
            if (req[(last + k) % W]) return (last + k) % W;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] model_onehot(input int g);
        logic [W-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Reference: who holds the output after each edge, from the arbitration rules.
    always @(posedge clk_i) begin
        if (!rstn_i) begin
            m_grant = -1;
            m_last  = W - 1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (!(m_grant >= 0 && request_i[m_grant])) begin
                m_grant = rr_search(request_i, m_last);
                if (m_grant >= 0) m_last = m_grant;
            end
        end
        m_prev_req = request_i;
    end

    // Compare process: mid-cycle, DUT against reference and the grant invariants.
    always @(negedge clk_i) begin
        if (m_valid) begin
            checks++;
            if (grant_o !== model_onehot(m_grant)) begin
                errors++;
                $display("FAIL model_cmp t=%0t grant=%b expected=%b", $time, grant_o, model_onehot(m_grant));
            end
            checks++;
            if ($countones(grant_o) > 1 || (grant_o & ~m_prev_req) != '0) begin
                errors++;
                $display("FAIL invariant t=%0t grant=%b req_at_edge=%b", $time, grant_o, m_prev_req);
            end
        end
    end

    task automatic step(input logic rst, input logic [W-1:0] req, input logic [W-1:0] exp, input string name);
        @(negedge clk_i);
        rstn_i    = rst;
        request_i = req;
        @(posedge clk_i);
        #1;
        checks++;
        if (grant_o !== exp) begin
            errors++;
            $display("FAIL %s grant=%b expected=%b", name, grant_o, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [W-1:0] req);
        @(negedge clk_i);
        rstn_i    = rst;
        request_i = req;
    endtask

    initial begin
        rstn_i    = 1'b0;
        request_i = 3'b111;

        // 1. reset held with all requesting
        step(1'b0, 3'b111, 3'b000, "reset_1");
        step(1'b0, 3'b111, 3'b000, "reset_2");
        // 2. index 0 wins first and holds
        step(1'b1, 3'b111, 3'b001, "first_grant");
        for (int i = 0; i < 3; i++) step(1'b1, 3'b111, 3'b001, "hold_0");
        // 3. release moves to 1 without idle, then 1 holds
        step(1'b1, 3'b110, 3'b010, "release_to_1");
        step(1'b1, 3'b111, 3'b010, "hold_1");
        // 4. to 2, then wrap-around to 0
        step(1'b1, 3'b101, 3'b100, "to_2");
        step(1'b1, 3'b011, 3'b001, "wrap_to_0");
        // 5. idle keeps the pointer
        step(1'b1, 3'b000, 3'b000, "idle");
        step(1'b1, 3'b011, 3'b010, "pointer_kept");
        // 6. between-edge glitches; only the value at the edge counts
        @(negedge clk_i);
        request_i = 3'b110;
        #1 request_i = 3'b010;
        #1 request_i = 3'b011;
        #1 request_i = 3'b001;
        #1 request_i = 3'b100;
        @(posedge clk_i);
        #1;
        checks++;
        if (grant_o !== 3'b100) begin
            errors++;
            $display("FAIL glitch grant=%b expected=%b", grant_o, 3'b100);
        end
        // 7. reset mid-transfer
        step(1'b1, 3'b010, 3'b010, "pre_reset_1");
        step(1'b0, 3'b010, 3'b000, "mid_reset");
        step(1'b1, 3'b111, 3'b001, "post_reset");
        // Sweeps of every request pattern, checked by the reference each cycle
        for (int r = 0; r < 8; r++) drive(1'b1, 3'(r));
        for (int r = 7; r >= 0; r--) drive(1'b1, 3'(r));
        for (int r = 0; r < 8; r++) drive(1'b1, 3'(r ^ 5));
        drive(1'b1, 3'b000);
        @(negedge clk_i);
        @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
